// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pipe_pkg
//  Description : Shared constants for the RV core pipeline stage registers.
//                OCC_* values double as the skid-stage FSM state encoding,
//                so the state register is directly the occupancy count.
//                RV_NOP is the canonical bubble (addi x0,x0,0) that callers
//                pass as RESET_VALUE on instruction-carrying stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t        OCC_EMPTY = 2'd0;
    localparam occ_t        OCC_ONE   = 2'd1;
    localparam occ_t        OCC_FULL  = 2'd2;

    localparam logic [31:0] RV_NOP    = 32'h0000_0013;

endpackage : rv_pipe_pkg
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Enable register with synchronous active-low reset and a
//                synchronous clear. Both reset and clear load RESET_VALUE;
//                otherwise the register loads i_d when i_en is high.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous reset, active low
//                i_clr  - synchronous clear to RESET_VALUE
//                i_en   - load enable
//                i_d    - data in  [WIDTH-1:0]
//                o_q    - data out [WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register with valid/ready handshake,
//                synchronous flush and optional 2-entry skid buffer.
//                SKID=1 : registered in_ready, full throughput.
//                SKID=0 : single entry, in_ready = !out_valid | out_ready.
//  Ports       : clk, rst_n (sync, active low), flush (sync discard)
//                in_valid / in_ready / in_data    - upstream side
//                out_valid / out_ready / out_data - downstream side
//                occupancy [1:0]                  - entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import rv_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SKID        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    occ_t             r_occ;
    occ_t             w_occ_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic             w_main_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_out_valid = (r_occ != OCC_EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM: next state and main-entry load control.
    // The main entry always holds the oldest word; the skid entry only
    // ever holds the second-oldest, so a pop from FULL promotes skid.
    // ------------------------------------------------------------------
    always_comb begin
        w_occ_nxt = r_occ;
        w_main_en = 1'b0;
        w_main_d  = in_data;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_occ_nxt = OCC_ONE;
                    w_main_en = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_pop) begin
                    // Replace in the same edge: no bubble.
                    w_main_en = 1'b1;
                end else if (w_accept) begin
                    // New word parks in the skid entry (SKID=1 only;
                    // unreachable with the combinational ready).
                    w_occ_nxt = OCC_FULL;
                end else if (w_pop) begin
                    w_occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_occ_nxt = OCC_ONE;
                    w_main_en = 1'b1;
                    w_main_d  = w_skid_q;
                end
            end
            default: begin
                w_occ_nxt = OCC_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main (output) entry
    // ------------------------------------------------------------------
    register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    // ------------------------------------------------------------------
    // Skid entry and ready generation
    // ------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_en;
            logic r_in_ready;

            assign w_skid_en = w_accept & ~w_pop & (r_occ == OCC_ONE);

            register #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (flush),
                .i_en  (w_skid_en),
                .i_d   (in_data),
                .o_q   (w_skid_q)
            );

            // Registered copy of (next occupancy != FULL) so that
            // in_ready carries no combinational path from out_ready.
            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_occ_nxt != OCC_FULL);
                end
            end

            assign w_in_ready = r_in_ready;
        end else begin : g_no_skid
            assign w_skid_q   = '0;
            assign w_in_ready = ~w_out_valid | out_ready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_main_q;
    assign occupancy = r_occ;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. Two instances
//                (SKID=0 and SKID=1) share one stimulus; each has its own
//                scoreboard queue fed on accepted inputs and drained on
//                output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import rv_pipe_pkg::*;

    localparam logic [31:0] RV = RV_NOP;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        ir0, ov0, ir1, ov1;
    logic [31:0] od0, od1;
    logic [1:0]  oc0, oc1;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic [31:0] hold0, hold1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV_NOP), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(oc0)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV_NOP), .SKID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1)
    );

    // ------------------------------------------------------------------
    // Scoreboard monitors, sampled on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            q0.delete();
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                n_checks++;
                if (ov0 !== 1'b1 || od0 !== hold0) begin
                    n_fail++;
                    $display("FAIL sb0_stall_stable valid=%b data=%h required valid=1 data=%h", ov0, od0, hold0);
                end
            end
            n_checks++;
            if (q0.size() > 1 || oc0 !== 2'(q0.size())) begin
                n_fail++;
                $display("FAIL sb0_occupancy got %0d required %0d", oc0, q0.size());
            end
            n_checks++;
            if (ov0 !== (oc0 != 2'd0) || ir0 !== (~ov0 | out_ready)) begin
                n_fail++;
                $display("FAIL sb0_flags valid=%b ready=%b occ=%0d out_ready=%b", ov0, ir0, oc0, out_ready);
            end
            if (ov0 && out_ready) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb0_spurious got %h required no output", od0);
                end else begin
                    e = q0.pop_front();
                    if (od0 !== e) begin
                        n_fail++;
                        $display("FAIL sb0_data got %h required %h", od0, e);
                    end
                end
            end
            if (flush) q0.delete();
            else if (in_valid && ir0) q0.push_back(in_data);
            stall0 = !flush && ov0 && !out_ready;
            hold0  = od0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            q1.delete();
            stall1 = 1'b0;
        end else begin
            if (stall1) begin
                n_checks++;
                if (ov1 !== 1'b1 || od1 !== hold1) begin
                    n_fail++;
                    $display("FAIL sb1_stall_stable valid=%b data=%h required valid=1 data=%h", ov1, od1, hold1);
                end
            end
            n_checks++;
            if (q1.size() > 2 || oc1 !== 2'(q1.size())) begin
                n_fail++;
                $display("FAIL sb1_occupancy got %0d required %0d", oc1, q1.size());
            end
            n_checks++;
            if (ov1 !== (oc1 != 2'd0) || ir1 !== (oc1 != 2'd2)) begin
                n_fail++;
                $display("FAIL sb1_flags valid=%b ready=%b occ=%0d", ov1, ir1, oc1);
            end
            if (ov1 && out_ready) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb1_spurious got %h required no output", od1);
                end else begin
                    e = q1.pop_front();
                    if (od1 !== e) begin
                        n_fail++;
                        $display("FAIL sb1_data got %h required %h", od1, e);
                    end
                end
            end
            if (flush) q1.delete();
            else if (in_valid && ir1) q1.push_back(in_data);
            stall1 = !flush && ov1 && !out_ready;
            hold1  = od1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (ov0 !== 1'b0 || od0 !== RV || oc0 !== 2'd0 || ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset0 v=%b d=%h occ=%0d rdy=%b required 0 %h 0 1", ov0, od0, oc0, ir0, RV);
        end
        n_checks++;
        if (ov1 !== 1'b0 || od1 !== RV || oc1 !== 2'd0 || ir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset1 v=%b d=%h occ=%0d rdy=%b required 0 %h 0 1", ov1, od1, oc1, ir1, RV);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_streaming;
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            in_valid = 1'b1; in_data = 32'(v);
            tick();
            n_checks++;
            if (ov0 !== 1'b1 || od0 !== 32'(v) || ov1 !== 1'b1 || od1 !== 32'(v)) begin
                n_fail++;
                $display("FAIL stream_%0d got %b/%h %b/%h required 1/%h", v, ov0, od0, ov1, od1, 32'(v));
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain valid got %b/%b required 0/0", ov0, ov1);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            tick();
            n_checks++;
            if (ov1 !== 1'b1 || od1 !== 32'hA) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got %b/%h required 1/%h", i, ov1, od1, 32'hA);
            end
        end
        n_checks++;
        if (oc1 !== 2'd2 || ir1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full occ=%0d ready=%b required 2 0", oc1, ir1);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (od1 !== 32'hB || oc1 !== 2'd1 || ir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop_a data=%h occ=%0d ready=%b required %h 1 1", od1, oc1, ir1, 32'hB);
        end
        tick();
        n_checks++;
        if (od1 !== 32'hC || oc1 !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_pop_b data=%h occ=%0d required %h 1", od1, oc1, 32'hC);
        end
        in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (oc1 !== 2'd0 || oc0 !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_drain occ got %0d/%0d required 0/0", oc0, oc1);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        n_checks++;
        if (oc1 !== 2'd2 || od1 !== 32'h11) begin
            n_fail++;
            $display("FAIL flush_pre occ=%0d data=%h required 2 %h", oc1, od1, 32'h11);
        end
        flush = 1'b1; in_data = 32'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (oc0 !== 2'd0 || ov0 !== 1'b0 || od0 !== RV || ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush0 occ=%0d v=%b d=%h rdy=%b required 0 0 %h 1", oc0, ov0, od0, ir0, RV);
        end
        n_checks++;
        if (oc1 !== 2'd0 || ov1 !== 1'b0 || od1 !== RV || ir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush1 occ=%0d v=%b d=%h rdy=%b required 0 0 %h 1", oc1, ov1, od1, ir1, RV);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_after_%0d valid got %b/%b data %h/%h required 0/0", i, ov0, ov1, od0, od1);
            end
        end
    endtask

    task automatic test_simul_push_pop;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        tick();
        n_checks++;
        if (oc1 !== 2'd1 || od1 !== 32'h5 || oc0 !== 2'd1 || od0 !== 32'h5) begin
            n_fail++;
            $display("FAIL pp_pre occ=%0d/%0d data=%h/%h required 1 %h", oc0, oc1, od0, od1, 32'h5);
        end
        in_data = 32'h6; out_ready = 1'b1;
        tick();
        n_checks++;
        if (oc1 !== 2'd1 || od1 !== 32'h6 || oc0 !== 2'd1 || od0 !== 32'h6) begin
            n_fail++;
            $display("FAIL pp_post occ=%0d/%0d data=%h/%h required 1 %h", oc0, oc1, od0, od1, 32'h6);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain left %0d/%0d valid %b/%b required 0/0", q0.size(), q1.size(), ov0, ov1);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simul_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
